// File: rtl/hp_read_arb.sv
// Two-requester AXI-style read arbiter onto one HP port; optional burst counters under HP_READ_ARB_STATS_EN.
// Latency: grant registered one cycle after arvalid, R routed combinationally from the order-FIFO head.
// Backpressure: no new grant while MAX_OUTST bursts are outstanding; R stalls follow the head requester's rready.
module hp_read_arb_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_wr;
  logic             do_rd;

  assign rd_vld = (count != '0);
  assign full   = (count == DEPTH_CNT);
  assign rd_dat = mem[rd_ptr];
  assign do_rd  = rd_rdy & rd_vld;
  // A same-cycle pop frees the slot, so a write is taken even when full.
  assign do_wr  = wr_vld & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module hp_read_arb #(
  parameter int HP_ADDR_WIDTH = 48,
  parameter int HP_DATA_WIDTH = 128,
  parameter int MAX_OUTST     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HP_ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]               s0_arlen,
  input  logic [2:0]               s0_arsize,
  input  logic [1:0]               s0_arburst,
  input  logic                     s0_arvalid,
  output logic                     s0_arready,
  output logic [HP_DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]               s0_rresp,
  output logic                     s0_rlast,
  output logic                     s0_rvalid,
  input  logic                     s0_rready,
  input  logic [HP_ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]               s1_arlen,
  input  logic [2:0]               s1_arsize,
  input  logic [1:0]               s1_arburst,
  input  logic                     s1_arvalid,
  output logic                     s1_arready,
  output logic [HP_DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]               s1_rresp,
  output logic                     s1_rlast,
  output logic                     s1_rvalid,
  input  logic                     s1_rready,
  output logic [HP_ADDR_WIDTH-1:0] hp_araddr,
  output logic [7:0]               hp_arlen,
  output logic [2:0]               hp_arsize,
  output logic [1:0]               hp_arburst,
  output logic                     hp_arvalid,
  input  logic                     hp_arready,
  input  logic [HP_DATA_WIDTH-1:0] hp_rdata,
  input  logic [1:0]               hp_rresp,
  input  logic                     hp_rlast,
  input  logic                     hp_rvalid,
  output logic                     hp_rready
`ifdef HP_READ_ARB_STATS_EN
  ,
  output logic [31:0]              stat_bursts0,
  output logic [31:0]              stat_bursts1
`endif
);
  typedef enum logic {IDLE, ISSUE} ar_state_t;

  ar_state_t                state;
  logic                     last_grant;
  logic                     grant;
  logic                     ar_vld_q;
  logic [HP_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]               ar_len_q;
  logic [2:0]               ar_size_q;
  logic [1:0]               ar_burst_q;

  logic pick_s1;
  logic ar_start;
  logic ar_hs;
  logic ord_full;
  logic ord_vld;
  logic ord_head;
  logic r_last_hs;

  // Round robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    pick_s1  = 1'b0;
    ar_start = 1'b0;
    pick_s1  = s1_arvalid & (~s0_arvalid | ~last_grant);
    ar_start = (state == IDLE) & (s0_arvalid | s1_arvalid) & ~ord_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      ar_vld_q   <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_start) begin
            state      <= ISSUE;
            ar_vld_q   <= 1'b1;
            grant      <= pick_s1;
            last_grant <= pick_s1;
            ar_addr_q  <= pick_s1 ? s1_araddr  : s0_araddr;
            ar_len_q   <= pick_s1 ? s1_arlen   : s0_arlen;
            ar_size_q  <= pick_s1 ? s1_arsize  : s0_arsize;
            ar_burst_q <= pick_s1 ? s1_arburst : s0_arburst;
          end
        end
        ISSUE: begin
          if (hp_arready) begin
            state    <= IDLE;
            ar_vld_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ar_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign ar_hs      = ar_vld_q & hp_arready;
  assign hp_arvalid = ar_vld_q;
  assign hp_araddr  = ar_addr_q;
  assign hp_arlen   = ar_len_q;
  assign hp_arsize  = ar_size_q;
  assign hp_arburst = ar_burst_q;
  assign s0_arready = ar_hs & ~grant;
  assign s1_arready = ar_hs & grant;

  // Grants are only made below capacity, so every AR handshake finds a free slot.
  hp_read_arb_order_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTST)
  ) u_order_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (ar_hs),
    .wr_dat (grant),
    .rd_rdy (r_last_hs),
    .rd_vld (ord_vld),
    .rd_dat (ord_head),
    .full   (ord_full)
  );

  assign hp_rready = ord_vld & (ord_head ? s1_rready : s0_rready);
  assign s0_rvalid = ord_vld & ~ord_head & hp_rvalid;
  assign s1_rvalid = ord_vld & ord_head & hp_rvalid;
  assign r_last_hs = hp_rvalid & hp_rready & hp_rlast;

  assign s0_rdata = hp_rdata;
  assign s0_rresp = hp_rresp;
  assign s0_rlast = hp_rlast;
  assign s1_rdata = hp_rdata;
  assign s1_rresp = hp_rresp;
  assign s1_rlast = hp_rlast;

`ifdef HP_READ_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts0 <= '0;
      stat_bursts1 <= '0;
    end else begin
      if (s0_arready) stat_bursts0 <= stat_bursts0 + 32'd1;
      if (s1_arready) stat_bursts1 <= stat_bursts1 + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hp_read_arb.sv
// Directed bench for hp_read_arb: cycle vector table plus multi-cycle ordering/full/reset sequences.
module tb_hp_read_arb;
  localparam logic [47:0] A0 = 48'h0000_1111_0000;
  localparam logic [47:0] A1 = 48'h0000_2222_0040;
  localparam logic [47:0] A2 = 48'h0000_3333_0080;
  localparam logic [47:0] A3 = 48'h0000_4444_00C0;
  localparam logic [47:0] A4 = 48'h0000_5555_0100;
  localparam logic [47:0] A5 = 48'h0000_6666_0140;

  logic         clk;
  logic         rst;
  logic [47:0]  s0_araddr, s1_araddr, hp_araddr;
  logic [7:0]   s0_arlen, s1_arlen, hp_arlen;
  logic [2:0]   s0_arsize, s1_arsize, hp_arsize;
  logic [1:0]   s0_arburst, s1_arburst, hp_arburst;
  logic         s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [127:0] s0_rdata, s1_rdata, hp_rdata;
  logic [1:0]   s0_rresp, s1_rresp, hp_rresp;
  logic         s0_rlast, s1_rlast, hp_rlast;
  logic         s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic         hp_arvalid, hp_arready, hp_rvalid, hp_rready;
`ifdef HP_READ_ARB_STATS_EN
  logic [31:0]  stat_bursts0, stat_bursts1;
`endif

  int vectors = 0;
  int miscompares = 0;

  hp_read_arb #(.HP_ADDR_WIDTH(48), .HP_DATA_WIDTH(128), .MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .hp_araddr(hp_araddr), .hp_arlen(hp_arlen), .hp_arsize(hp_arsize), .hp_arburst(hp_arburst),
    .hp_arvalid(hp_arvalid), .hp_arready(hp_arready),
    .hp_rdata(hp_rdata), .hp_rresp(hp_rresp), .hp_rlast(hp_rlast), .hp_rvalid(hp_rvalid), .hp_rready(hp_rready)
`ifdef HP_READ_ARB_STATS_EN
    , .stat_bursts0(stat_bursts0), .stat_bursts1(stat_bursts1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  // Record: in = {rst,s0_arvalid,s1_arvalid,hp_arready,hp_rvalid,hp_rlast,s0_rready,s1_rready}
  //         exp = {hp_arvalid,s0_arready,s1_arready,hp_rready,s0_rvalid,s1_rvalid}, asel 1=A0 2=A1
  typedef struct packed {
    logic [7:0] in;
    logic [5:0] exp;
    logic [1:0] asel;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; hp_arready = 1'b0;
    hp_rvalid = 1'b0; hp_rlast = 1'b0; hp_rdata = '0; hp_rresp = '0;
    s0_rready = 1'b0; s1_rready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [47:0] addr, input logic [7:0] len);
    if (n == 0) begin
      s0_araddr = addr; s0_arlen = len; s0_arvalid = 1'b1;
    end else begin
      s1_araddr = addr; s1_arlen = len; s1_arvalid = 1'b1;
    end
  endtask

  task automatic wait_grant(input int n, input logic [47:0] addr, input logic [7:0] len, input string name);
    bit done;
    done = 1'b0;
    hp_arready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      #2;
      if ((n == 0) ? s0_arready : s1_arready) begin
        check({name, "_addr"}, 128'(hp_araddr), 128'(addr));
        check({name, "_len"}, 128'(hp_arlen), 128'(len));
        check({name, "_szb"}, 128'({hp_arsize, hp_arburst}), (n == 0) ? 128'(5'b100_01) : 128'(5'b011_10));
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no arready, expected arready within 20 cycles", name);
    end
    if (n == 0) s0_arvalid = 1'b0;
    else s1_arvalid = 1'b0;
  endtask

  task automatic issue(input int n, input logic [47:0] addr, input logic [7:0] len, input string name);
    set_req(n, addr, len);
    wait_grant(n, addr, len, name);
  endtask

  task automatic wait_arvalid(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #2;
      seen = hp_arvalid;
      @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no hp_arvalid, expected it within 10 cycles", name);
    end
  endtask

  task automatic expect_blocked(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    hp_arready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      #2;
      seen = seen | hp_arvalid | s0_arready | s1_arready;
      @(negedge clk);
    end
    check(name, 128'(seen), 128'(0));
  endtask

  task automatic beat(input logic [127:0] d, input logic last, input int dst, input string name);
    hp_rvalid = 1'b1; hp_rdata = d; hp_rresp = d[1:0]; hp_rlast = last;
    s0_rready = 1'b1; s1_rready = 1'b1;
    #2;
    check({name, "_route"}, 128'({s0_rvalid, s1_rvalid, hp_rready}), 128'({dst == 0, dst == 1, 1'b1}));
    check({name, "_data"}, (dst == 0) ? s0_rdata : s1_rdata, d);
    check({name, "_resp_last"},
          128'({(dst == 0) ? s0_rresp : s1_rresp, (dst == 0) ? s0_rlast : s1_rlast}),
          128'({d[1:0], last}));
    @(negedge clk);
    hp_rvalid = 1'b0; hp_rlast = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
  endtask

  initial begin
    logic [5:0]  outs;
    logic [47:0] exp_addr;
    logic [127:0] d;

    tbl[0]  = {8'b1111_0000, 6'b000000, 2'd0};
    tbl[1]  = {8'b0111_0000, 6'b000000, 2'd0};
    tbl[2]  = {8'b0111_0000, 6'b110000, 2'd1};
    tbl[3]  = {8'b0111_0000, 6'b000000, 2'd0};
    tbl[4]  = {8'b0111_0000, 6'b101000, 2'd2};
    tbl[5]  = {8'b0111_0000, 6'b000000, 2'd0};
    tbl[6]  = {8'b0111_0000, 6'b110000, 2'd1};
    tbl[7]  = {8'b0000_1011, 6'b000110, 2'd0};
    tbl[8]  = {8'b0000_1111, 6'b000110, 2'd0};
    tbl[9]  = {8'b0000_1110, 6'b000001, 2'd0};
    tbl[10] = {8'b0000_1111, 6'b000101, 2'd0};
    tbl[11] = {8'b0000_0010, 6'b000100, 2'd0};
    tbl[12] = {8'b0000_1110, 6'b000110, 2'd0};
    tbl[13] = {8'b0000_1111, 6'b000000, 2'd0};
    tbl[14] = {8'b0010_0000, 6'b000000, 2'd0};
    tbl[15] = {8'b0010_0000, 6'b100000, 2'd2};
    tbl[16] = {8'b0010_0000, 6'b100000, 2'd2};
    tbl[17] = {8'b0011_0000, 6'b101000, 2'd2};
    tbl[18] = {8'b0000_0000, 6'b000000, 2'd0};
    tbl[19] = {8'b1000_0000, 6'b000000, 2'd0};
    tbl[20] = {8'b0000_1111, 6'b000000, 2'd0};

    s0_araddr = A0; s0_arlen = 8'd0; s0_arsize = 3'd4; s0_arburst = 2'b01;
    s1_araddr = A1; s1_arlen = 8'd0; s1_arsize = 3'd3; s1_arburst = 2'b10;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      {rst, s0_arvalid, s1_arvalid, hp_arready, hp_rvalid, hp_rlast, s0_rready, s1_rready} = tbl[i].in;
      #2;
      outs = {hp_arvalid, s0_arready, s1_arready, hp_rready, s0_rvalid, s1_rvalid};
      exp_addr = (tbl[i].asel == 2'd2) ? A1 : A0;
      vectors++;
      if (outs !== tbl[i].exp || (tbl[i].asel != 2'd0 && hp_araddr !== exp_addr)) begin
        miscompares++;
        $display("FAIL vec%0d: got ctl=%b addr=%h, expected ctl=%b addr=%h",
                 i, outs, hp_araddr, tbl[i].exp, exp_addr);
      end
      @(negedge clk);
    end

    // Burst ordering: 4-beat burst for s0 then single beat for s1.
    do_reset();
    issue(0, A0, 8'd3, "b_s0");
    issue(1, A1, 8'd0, "b_s1");
    for (int b = 1; b <= 5; b++) begin
      d = {64'(b), 64'hCAFE_0000_0000_0000 + 64'(b)};
      beat(d, (b == 4) || (b == 5), (b == 5) ? 1 : 0, "b_beat");
    end
`ifdef HP_READ_ARB_STATS_EN
    check("b_stat0", 128'(stat_bursts0), 128'(1));
    check("b_stat1", 128'(stat_bursts1), 128'(1));
`endif

    // Full FIFO blocks further grants until a last-beat pop.
    do_reset();
    issue(0, A0, 8'd0, "c_i0");
    issue(1, A1, 8'd0, "c_i1");
    issue(0, A2, 8'd0, "c_i2");
    issue(1, A3, 8'd0, "c_i3");
    set_req(0, A4, 8'd0);
    expect_blocked(6, "c_full_block");
    beat(128'h11, 1'b1, 0, "c_pop");
    wait_grant(0, A4, 8'd0, "c_regrant");

    // Pop coinciding with an AR handshake, then order and occupancy checks.
    beat(128'h22, 1'b1, 1, "d_pop1");
    set_req(1, A3, 8'd0);
    hp_arready = 1'b0;
    wait_arvalid("d_wait");
    hp_arready = 1'b1; hp_rvalid = 1'b1; hp_rlast = 1'b1; hp_rdata = 128'h33;
    s0_rready = 1'b1; s1_rready = 1'b1;
    #2;
    check("d_coincide", 128'({s1_arready, s0_arready, s0_rvalid, s1_rvalid, hp_rready}), 128'(5'b10101));
    check("d_coincide_addr", 128'(hp_araddr), 128'(A3));
    @(negedge clk);
    idle_inputs();
    issue(0, A4, 8'd0, "d_fill");
    set_req(1, A5, 8'd0);
    expect_blocked(4, "d_full_block");
    beat(128'h40, 1'b1, 1, "d_drain0");
    wait_grant(1, A5, 8'd0, "d_regrant");
    beat(128'h41, 1'b1, 0, "d_drain1");
    beat(128'h42, 1'b1, 1, "d_drain2");
    beat(128'h43, 1'b1, 0, "d_drain3");
    beat(128'h44, 1'b1, 1, "d_drain4");

    // Reset while in ISSUE with two bursts outstanding.
    do_reset();
    issue(0, A0, 8'd0, "e_i0");
    issue(1, A1, 8'd0, "e_i1");
`ifdef HP_READ_ARB_STATS_EN
    check("e_stats_pre", 128'({stat_bursts0, stat_bursts1}), 128'({32'd1, 32'd1}));
`endif
    set_req(0, A2, 8'd0);
    hp_arready = 1'b0;
    wait_arvalid("e_wait");
    rst = 1'b1;
    s0_arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hp_rvalid = 1'b1; hp_rlast = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
    #2;
    check("e_post_reset",
          128'({hp_arvalid, hp_rready, s0_rvalid, s1_rvalid, s0_arready, s1_arready}), 128'(0));
`ifdef HP_READ_ARB_STATS_EN
    check("e_stats_post", 128'({stat_bursts0, stat_bursts1}), 128'(0));
`endif
    @(negedge clk);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hp_read_arb.md
HP_READ_ARB -- requirements
Module: hp_read_arb

Interface
REQ-001 SHALL have parameter HP_ADDR_WIDTH, default 48: AR address width.
REQ-002 SHALL have parameter HP_DATA_WIDTH, default 128: R data width.
REQ-003 SHALL have parameter MAX_OUTST, default 4 (power of 2, 2..16): outstanding bursts tracked.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port sN_araddr (N=0,1), input, HP_ADDR_WIDTH: requester N burst address.
REQ-007 SHALL have port sN_arlen, input, 8: requester N burst length minus 1.
REQ-008 SHALL have port sN_arsize/sN_arburst, input, 3/2: requester N size and burst type.
REQ-009 SHALL have port sN_arvalid, input, 1; sN_arready, output, 1: requester N AR handshake.
REQ-010 SHALL have port sN_rdata, output, HP_DATA_WIDTH; sN_rresp, output, 2; sN_rlast, output, 1: requester N R payload.
REQ-011 SHALL have port sN_rvalid, output, 1; sN_rready, input, 1: requester N R handshake.
REQ-012 SHALL have ports hp_araddr/arlen/arsize/arburst/arvalid, output, and hp_arready, input, with widths HP_ADDR_WIDTH/8/3/2/1/1: shared HP AR channel.
REQ-013 SHALL have ports hp_rdata/rresp/rlast/rvalid, input, and hp_rready, output, with widths HP_DATA_WIDTH/2/1/1/1: shared HP R channel.

Function
REQ-014 SHALL run an AR FSM with states IDLE, ISSUE. IDLE->ISSUE when either arvalid=1 and the order FIFO is not full. ISSUE->IDLE on the hp_arvalid&hp_arready handshake.
REQ-015 SHALL arbitrate round-robin in IDLE. Last-granted starts at 1 after reset, so s0 wins the first tie. The requester not granted last wins any tie.
REQ-016 SHALL register the granted AR fields on the IDLE->ISSUE edge. hp_arvalid=1 throughout ISSUE, and the fields SHALL stay stable until the handshake.
REQ-017 SHALL assert sN_arready for exactly one cycle, coincident with the hp AR handshake, only for the granted N.
REQ-018 SHALL push the grant ID into an order FIFO of depth MAX_OUTST on each hp AR handshake.
REQ-019 SHALL stay in IDLE while the FIFO is full, with no new grant.
REQ-020 SHALL route R combinationally to the requester at the FIFO head:
- sH_rvalid = hp_rvalid
- hp_rready = sH_rready
- the other requester's rvalid = 0
REQ-021 SHALL pop the FIFO on the hp_rvalid&hp_rready&hp_rlast beat.
REQ-022 SHALL hold hp_rready=0 and all sN_rvalid=0 when the FIFO is empty.
REQ-023 SHALL handle a push and pop in the same cycle as count unchanged, including when the FIFO is full. The pop makes room for the push.
REQ-024 SHALL keep FIFO pointers log2(MAX_OUTST) bits wide and wrap modulo MAX_OUTST. The count SHALL be log2(MAX_OUTST)+1 bits.
REQ-025 SHALL pass rresp unmodified. rresp has no effect on routing or pop.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, enter:
- FSM = IDLE
- FIFO empty, pointers 0
- last-granted = 1
- registered AR fields = 0
REQ-027 SHALL drive these outputs while in reset and in the first cycle after: hp_arvalid=0, sN_arready=0, sN_rvalid=0, hp_rready=0.
REQ-028 SHALL, on reset mid-burst, discard in-flight ordering state with no further routing. Downstream reset is the system's responsibility.

Configuration
REQ-029 SHALL compile per-requester statistics when HP_READ_ARB_STATS_EN is defined:
- outputs stat_bursts0 and stat_bursts1, 32 bits each
- each increments on that requester's AR handshake
- each wraps at 2^32
- each resets to 0
REQ-030 SHALL, without HP_READ_ARB_STATS_EN, omit those ports and counters, with identical remaining behaviour.

Verification
REQ-031 SHALL cover this scenario: s0 and s1 arvalid together from reset, hp_arready=1. Response: grants s0, then s1, then s0, and hp_araddr matches each granted requester's address.
REQ-032 SHALL cover this scenario: s0 issues arlen=3, s1 issues arlen=0, R returns 5 beats in order. Response: s0 receives beats 1-4 with rlast on beat 4, then s1 receives beat 5 with rlast.
REQ-033 SHALL cover this scenario: MAX_OUTST=4, 4 bursts issued, no R returned. Response: 5th arvalid sees no arready until one rlast pop.
REQ-034 SHALL cover this scenario: FIFO full, a final-beat pop coincides with a new AR handshake. Response: count stays 4 and the order is preserved.
REQ-035 SHALL cover this scenario: s1_rready=0 while head=s1 and hp_rvalid=1. Response: hp_rready=0, data held, s0_rvalid=0.
REQ-036 SHALL cover this scenario: rst asserted in ISSUE with 2 bursts outstanding. Response: next cycle hp_arvalid=0, hp_rready=0, and with STATS_EN both counters are 0.
